// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-stage registers: occupancy states and
// default payload width / NOP encoding.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam int          DEF_DATA_W = 64;
    // MIPS sll $0,$0,0
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_en && (r_cnt != '1))
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, optional skid entry,
// hazard hold, NOP-inserting flush and a saturating bubble counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter logic [DATA_W-1:0] FLUSH_MASK = DATA_W'(64'h0000_0000_FFFF_FFFF),
    parameter logic [DATA_W-1:0] NOP_VALUE  = DATA_W'({32'h0, NOP_INSTR}),
    parameter bit                SKID_EN    = 1'b1,
    parameter int                CNT_W      = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              hold,
    input  logic              flush,
    output logic [CNT_W-1:0]  bubble_cnt
);

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_main,  w_main_nxt;
    logic [DATA_W-1:0] r_skid,  w_skid_nxt;
    logic              w_accept, w_drain;

    // With the skid entry, in_ready is purely registered; without it, a full
    // stage can only take a beat when the current one leaves the same cycle.
    assign in_ready  = (SKID_EN ? (r_state != ST_SKID)
                                : ((r_state == ST_EMPTY) || out_ready)) && !hold;
    assign out_valid = (r_state != ST_EMPTY) && !hold;
    assign out_data  = r_main;

    assign w_accept = in_valid && in_ready;
    assign w_drain  = out_valid && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = (r_main & ~FLUSH_MASK) | (NOP_VALUE & FLUSH_MASK);
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_FULL;
                        w_main_nxt  = in_data;
                    end
                end
                ST_FULL: begin
                    if (w_accept && w_drain) begin
                        w_main_nxt = in_data;
                    end else if (w_accept) begin
                        w_state_nxt = ST_SKID;
                        w_skid_nxt  = in_data;
                    end else if (w_drain) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (w_drain) begin
                        w_state_nxt = ST_FULL;
                        w_main_nxt  = r_skid;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_EMPTY;
            r_main  <= NOP_VALUE;
            r_skid  <= NOP_VALUE;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .i_clk (CLK),
        .i_rst (RST),
        .i_en  (!out_valid),
        .o_cnt (bubble_cnt)
    );

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register used between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary-width payload with a valid/ready handshake, an optional one-entry skid buffer, a hazard-unit hold input and a flush input that inserts a bubble by overwriting selected payload bits with a NOP pattern. A saturating bubble counter exposes stall/flush pressure for performance debug.

## Interface
- DATA_W, 64, payload width (e.g. {PC+4, instruction}).
- FLUSH_MASK, {32'h0, 32'hFFFF_FFFF}, payload bits overwritten on flush.
- NOP_VALUE, 64'h0, value written into masked bits on flush; full reset value of out_data.
- SKID_EN, 1, 1 = two-entry (main + skid); 0 = single entry.
- CNT_W, 16, bubble counter width.

- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data holds a live beat.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  registered payload.
- hold  in  1  hazard hold: freeze stage.
- flush  in  1  kill all held beats, insert bubble.
- bubble_cnt  out  CNT_W  saturating count of cycles with out_valid=0.

## Operation
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- States (SKID_EN=1): EMPTY, FULL, SKID.
  - EMPTY: accept -> FULL, main <= in_data.
  - FULL: accept & !drain -> SKID, skid <= in_data; accept & drain -> FULL, main <= in_data; !accept & drain -> EMPTY.
  - SKID: drain -> FULL, main <= skid; no accept possible.
- in_ready (SKID_EN=1) = (state != SKID) & !hold; depends on registered state only, no path from out_ready.
- SKID_EN=0: states EMPTY/FULL only; in_ready = (state==EMPTY | out_ready) & !hold (combinational through out_ready, documented).
- out_valid = (state != EMPTY) & !hold; out_data = main register.
- hold: in_ready=0, out_valid=0, no state or data change; downstream sees a bubble.
- flush (priority over hold and handshake): next state EMPTY; skid discarded; any beat presented at in_data that cycle dropped even if in_ready=1; main <= (main & ~FLUSH_MASK) | (NOP_VALUE & FLUSH_MASK); unmasked bits keep old value.
- bubble_cnt increments each cycle out_valid=0; sticks at 2^CNT_W-1.

## Timing
- Reset (async assert, sync release by rising edge): state EMPTY, out_valid=0, in_ready=1 (if hold=0), out_data=NOP_VALUE, skid=NOP_VALUE, bubble_cnt=0.
- Latency: beat accepted at edge N appears on out_data with out_valid=1 after edge N (one cycle).
- Throughput: one beat/cycle while out_ready=1 and hold=0.
- Data on out_data stable while out_valid=1 & out_ready=0.
- Flush takes effect at the edge it is sampled; out_valid=0 the following cycle.
- Flush + hold same cycle: flush behaviour; next cycle hold applies to EMPTY stage.
- Reset mid-SKID: both entries lost, no beat emitted.
- Order preserved: skid beat never overtakes main beat.

## Structure
- Shared package pipe_pkg: state enum (EMPTY, FULL, SKID), default DATA_W, default NOP encoding (32'h0000_0000 for MIPS sll $0,$0,0).
- One sub-module: sat_counter (CNT_W, enable, async reset) for bubble_cnt, reusable by other perf counters.

## Test plan
- Reset, then in_data=64'h0000_0004_2002_0005, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_data=64'h0000_0004_2002_0005; stream of 8 beats emerges in order, one per cycle.
- SKID_EN=1, out_ready=0, send 3 beats A,B,C -> A in main, B in skid, in_ready=0 on C; raise out_ready -> A, B, C delivered, no loss or duplicate.
- FULL with main=64'h0000_0010_8C22_0000, pulse flush -> out_valid=0, out_data=64'h0000_0010_0000_0000; concurrent in_valid beat dropped.
- hold=1 for 3 cycles in FULL with out_ready=1 -> out_valid=0, in_ready=0, main unchanged, bubble_cnt +3; release -> same beat delivered.
- CNT_W=4, 20 idle cycles -> bubble_cnt reaches 15 and stays.
- SKID_EN=0, FULL with out_ready=1, in_valid=1 -> in_ready=1 same cycle, back-to-back throughput; out_ready=0 -> in_ready=0.
